kmeans_iter_ctrl: RTL

//  Iteration scheduler for the K-means clustering system. On start it runs repeated passes of

---
 rtl/kmeans_iter_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/kmeans_iter_ctrl.sv
// K-means iteration scheduler: clear, stream pixels round-robin to the engines, drain, divide each
// active cluster, update means, then repeat until the means are stable or the pass cap is reached.
module kmeans_iter_ctrl #(
   parameter int unsigned E         = 16,
   parameter int unsigned K         = 16,
   parameter int unsigned AW        = 20,
   parameter int unsigned MAX_ITER  = 32,
   parameter int unsigned DRAIN_MIN = 4,
   localparam int unsigned SEL_W    = $clog2(E),
   localparam int unsigned IDX_W    = $clog2(K),
   localparam int unsigned IT_W     = $clog2(MAX_ITER + 1),
   localparam int unsigned KE_W     = $clog2(K + 1),
   localparam int unsigned DC_W     = $clog2(DRAIN_MIN + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [AW-1:0]    i_img_size,
   input  logic [4:0]       i_k_cfg,
   output logic             o_pix_req,
   input  logic             i_pix_gnt,
   output logic [AW-1:0]    o_pix_addr,
   output logic [SEL_W-1:0] o_eng_sel,
   output logic             o_eng_clear,
   input  logic [E-1:0]     i_eng_busy,
   output logic             o_div_start,
   output logic [IDX_W-1:0] o_div_idx,
   input  logic             i_div_done,
   output logic             o_mean_update,
   input  logic             i_all_stable,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_converged,
   output logic [IT_W-1:0]  o_iter_count
);

   typedef enum logic [3:0] {
      StIdle, StClear, StStream, StDrain, StDivide, StDwait, StUpdate, StCheck, StDone
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_img_size;
   logic [KE_W-1:0]   r_k_eff;
   logic [AW-1:0]     r_pix_addr;
   logic [IDX_W-1:0]  r_div_idx;
   logic [IT_W-1:0]   r_iter;
   logic              r_conv;
   logic [DC_W-1:0]   r_drain_cnt;

   logic [KE_W-1:0]   w_k_eff;
   logic              w_last_pix;
   logic              w_last_div;
   logic              w_drain_ok;
   logic [IT_W-1:0]   w_iter_inc;
   logic              w_iter_max;

   always_comb begin
      if (i_k_cfg == '0) begin
         w_k_eff = KE_W'(1);
      end else if (32'(i_k_cfg) > K) begin
         w_k_eff = KE_W'(K);
      end else begin
         w_k_eff = KE_W'(i_k_cfg);
      end
   end

   assign w_last_pix = (r_pix_addr == r_img_size - AW'(1));
   assign w_last_div = (KE_W'(r_div_idx) == r_k_eff - KE_W'(1));
   // Counter saturates at DRAIN_MIN-1, reached on the DRAIN_MIN-th drain cycle.
   assign w_drain_ok = (r_drain_cnt >= DC_W'(DRAIN_MIN - 1)) && (i_eng_busy == '0);
   assign w_iter_inc = r_iter + IT_W'(1);
   assign w_iter_max = (w_iter_inc == IT_W'(MAX_ITER));

   always_comb begin
      w_state_nxt   = r_state;
      o_pix_req     = 1'b0;
      o_eng_clear   = 1'b0;
      o_div_start   = 1'b0;
      o_mean_update = 1'b0;
      o_done        = 1'b0;
      o_busy        = 1'b1;
      unique case (r_state)
         StIdle: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_state_nxt = (i_img_size == '0) ? StDone : StClear;
            end
         end
         StClear: begin
            o_eng_clear = 1'b1;
            w_state_nxt = StStream;
         end
         StStream: begin
            o_pix_req = 1'b1;
            if (i_pix_gnt && w_last_pix) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            if (w_drain_ok) begin
               w_state_nxt = StDivide;
            end
         end
         StDivide: begin
            o_div_start = 1'b1;
            w_state_nxt = StDwait;
         end
         StDwait: begin
            if (i_div_done) begin
               w_state_nxt = w_last_div ? StUpdate : StDivide;
            end
         end
         StUpdate: begin
            o_mean_update = 1'b1;
            w_state_nxt   = StCheck;
         end
         StCheck: begin
            if (i_all_stable || w_iter_max) begin
               w_state_nxt = StDone;
            end else begin
               w_state_nxt = StClear;
            end
         end
         StDone: begin
            o_done      = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_img_size  <= '0;
         r_k_eff     <= '0;
         r_pix_addr  <= '0;
         r_div_idx   <= '0;
         r_iter      <= '0;
         r_conv      <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_img_size <= i_img_size;
                  r_k_eff    <= w_k_eff;
                  r_iter     <= '0;
                  r_conv     <= 1'b0;
               end
            end
            StClear: begin
               r_pix_addr  <= '0;
               r_drain_cnt <= '0;
            end
            StStream: begin
               if (i_pix_gnt) begin
                  r_pix_addr <= r_pix_addr + AW'(1);
               end
            end
            StDrain: begin
               if (r_drain_cnt < DC_W'(DRAIN_MIN - 1)) begin
                  r_drain_cnt <= r_drain_cnt + DC_W'(1);
               end
               if (w_drain_ok) begin
                  r_div_idx <= '0;
               end
            end
            StDwait: begin
               if (i_div_done && !w_last_div) begin
                  r_div_idx <= r_div_idx + IDX_W'(1);
               end
            end
            StCheck: begin
               r_iter <= w_iter_inc;
               if (i_all_stable) begin
                  r_conv <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // E is a power of two, so the low address bits are the round-robin engine index.
   assign o_eng_sel    = r_pix_addr[SEL_W-1:0];
   assign o_pix_addr   = r_pix_addr;
   assign o_div_idx    = r_div_idx;
   assign o_iter_count = r_iter;
   assign o_converged  = r_conv;

endmodule
